lsu32_initiator: RTL and testbench

- Load/store unit between the core's execute stage and the word-organised data memory; the initiator side of the memory port.
- Takes one load/store request at a time in the funct3 encoding that data_memory32 uses for loadStoreMode (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- Converts each request into aligned word accesses with byte enables, performs lane steering and sign/zero extension, and returns one completion pulse.
- Splits boundary-crossing misaligned accesses into two sequential word accesses.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_lane_align.sv | 25 ++
 rtl/lsu32_initiator.sv | 94 +++++++++
 tb/tb_lsu32_initiator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: mode encodings, FSM states and size helpers shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  function automatic logic mode_ok(input logic [2:0] mode);
    return mode inside {LS_B, LS_H, LS_W, LS_BU, LS_HU};
  endfunction

  // Byte mask of the access size; invalid modes touch no lanes.
  function automatic logic [3:0] size_mask(input logic [2:0] mode);
    return !mode_ok(mode) ? 4'b0000 :
           mode[1] ? 4'b1111 :
           mode[0] ? 4'b0011 : 4'b0001;
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane steering and load extraction/extension over a two-word span
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  mode,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [63:0] span_data,
  output logic [7:0]  span_be,
  output logic [31:0] rdata
);
  logic [31:0] shifted;

  assign span_data = {32'b0, wdata} << {off, 3'b000};
  assign span_be   = {4'b0, size_mask(mode)} << off;
  assign shifted   = 32'({hi, lo} >> {off, 3'b000});

  // LW ignores the unsigned bit; sub-word loads sign-extend unless mode[2] is set.
  always_comb
    rdata = mode[1] ? shifted :
            mode[0] ? {{16{~mode[2] & shifted[15]}}, shifted[15:0]} :
                      {{24{~mode[2] & shifted[7]}}, shifted[7:0]};
endmodule

// File: rtl/lsu32_initiator.sv
// lsu32_initiator: one-at-a-time load/store unit driving a word-organised data memory
module lsu32_initiator
  import lsu_pkg::*;
#(
  parameter bit MISALIGNED_EN = 1'b1,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_mode,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);
  state_t state, next;
  logic wr_q, err_q, bad, act;
  logic [ADDR_W-1:0] addr_q, word_addr;
  logic [31:0] wdata_q, lo_q, hi_q, rdata;
  logic [2:0] mode_q;
  logic [63:0] span_data;
  logic [7:0] span_be, req_span;

  lsu_lane_align u_align (
    .wdata(wdata_q), .off(addr_q[1:0]), .mode(mode_q), .lo(lo_q), .hi(hi_q),
    .span_data(span_data), .span_be(span_be), .rdata(rdata)
  );

  assign req_span   = {4'b0, size_mask(req_mode)} << req_addr[1:0];
  assign bad        = !mode_ok(req_mode) || (!MISALIGNED_EN && |req_span[7:4]);
  assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign act        = !reset;
  assign resp_valid = act && state == RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid && !err_q && !wr_q ? rdata : '0;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;

  // Request latch and read-word capture at the exit of each access cycle.
  always_ff @(posedge clk)
    if (reset) {wr_q, err_q, addr_q, wdata_q, mode_q, lo_q, hi_q} <= '0;
    else if (state == IDLE && req_valid) begin
      wr_q    <= req_write;
      err_q   <= bad;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      mode_q  <= req_mode;
    end
    else if (state == ACC1) lo_q <= mem_rdata;
    else if (state == ACC2) hi_q <= mem_rdata;

  // Next state and memory port; reset silences the port so a cut-off store writes nothing more.
  always_comb begin
    next      = state;
    req_ready = state == IDLE;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_we    = 1'b0;
    case (state)
      IDLE: if (req_valid) next = bad ? RESP : ACC1;
      ACC1: begin
        next = |span_be[7:4] ? ACC2 : RESP;
        if (act) begin
          mem_addr  = word_addr;
          mem_wdata = span_data[31:0];
          mem_be    = span_be[3:0];
          mem_we    = wr_q;
        end
      end
      ACC2: begin
        next = RESP;
        if (act) begin
          mem_addr  = word_addr + ADDR_W'(4);
          mem_wdata = span_data[63:32];
          mem_be    = span_be[7:4];
          mem_we    = wr_q;
        end
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu32_initiator.sv
// tb_lsu32_initiator: scoreboard bench with a byte-level reference memory
module tb_lsu32_initiator;
  import lsu_pkg::*;

  logic clk = 0, reset = 1, req_valid = 0, req_valid0 = 0, req_write = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0] req_mode = 0;
  logic req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic req_ready0, resp_valid0, resp_err0, mem_we0;
  logic [31:0] resp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic [3:0] mem_be0;

  logic [31:0] mem_words[16];
  logic [7:0] ref_mem[64];
  logic [32:0] sb[$];
  int checks = 0, errors = 0, lat, nacc;
  logic [31:0] log_addr[4], log_wd[4];
  logic [3:0] log_be[4];
  logic log_we[4];

  lsu32_initiator #(.MISALIGNED_EN(1'b1), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  lsu32_initiator #(.MISALIGNED_EN(1'b0), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_be(mem_be0), .mem_we(mem_we0),
    .mem_rdata(mem_rdata0)
  );

  always #5 clk = ~clk;

  assign mem_rdata  = mem_words[mem_addr[5:2]];
  assign mem_rdata0 = mem_words[mem_addr0[5:2]];

  always @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem_words[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] m);
    logic [31:0] v = 0;
    int n = m[1] ? 4 : m[0] ? 2 : 1;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
    if (!m[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!m[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    logic [32:0] exp;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_mode = m;
    @(posedge clk);
    lat = 1; nacc = 0;
    @(negedge clk);
    req_valid = 0;
    while (!resp_valid && lat < 8) begin
      if (nacc < 4) begin
        log_addr[nacc] = mem_addr; log_wd[nacc] = mem_wdata; log_be[nacc] = mem_be; log_we[nacc] = mem_we;
        nacc++;
      end
      @(posedge clk); lat++; @(negedge clk);
    end
    exp = sb.pop_front();
    checks++;
    if (!resp_valid) begin errors++; $display("FAIL resp_timeout addr=%h lat=%0d", a, lat); end
    else if ({resp_err, resp_rdata} !== exp) begin
      errors++; $display("FAIL resp addr=%h mode=%b got err=%b data=%h want err=%b data=%h", a, m, resp_err, resp_rdata, exp[32], exp[31:0]);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m, input logic e);
    int n = m[1] ? 4 : m[0] ? 2 : 1;
    sb.push_back({e, (w || e) ? 32'h0 : exp_load(a, m)});
    if (w && !e) for (int i = 0; i < n; i++) ref_mem[a + i] = d[8*i +: 8];
    do_req(w, a, d, m);
  endtask

  task automatic test_reset;
    int pulses = 0;
    reset = 1; req_valid = 1; req_mode = LS_W; req_addr = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, resp_rdata, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got rv=%b we=%b be=%b addr=%h wd=%h want all 0", resp_valid, mem_we, mem_be, mem_addr, mem_wdata);
    end
    reset = 0; req_valid = 0;
    repeat (3) begin @(negedge clk); pulses += resp_valid; end
    checks++;
    if (pulses !== 0 || req_ready !== 1 || req_ready0 !== 1) begin
      errors++; $display("FAIL reset_idle got pulses=%0d ready=%b ready0=%b want 0 1 1", pulses, req_ready, req_ready0);
    end
  endtask

  task automatic test_word;
    issue(1, 0, 32'hDEADBEEF, LS_W, 0);
    checks++;
    if (lat !== 2 || nacc !== 1 || log_addr[0] !== 0 || log_be[0] !== 4'b1111 || log_we[0] !== 1 || log_wd[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw0 got lat=%0d addr=%h be=%b we=%b wd=%h want 2 0 1111 1 deadbeef", lat, log_addr[0], log_be[0], log_we[0], log_wd[0]);
    end
    issue(0, 0, 0, LS_W, 0);
    checks++;
    if (lat !== 2 || log_we[0] !== 0 || log_be[0] !== 4'b1111) begin
      errors++; $display("FAIL lw0 got lat=%0d we=%b be=%b want 2 0 1111", lat, log_we[0], log_be[0]);
    end
  endtask

  task automatic test_byte;
    issue(1, 13, 32'h000000AA, LS_B, 0);
    checks++;
    if (lat !== 2 || log_addr[0] !== 12 || log_be[0] !== 4'b0010 || log_wd[0] !== 32'h0000AA00 || log_we[0] !== 1) begin
      errors++; $display("FAIL sb13 got lat=%0d addr=%h be=%b wd=%h want 2 c 0010 0000aa00", lat, log_addr[0], log_be[0], log_wd[0]);
    end
    issue(0, 13, 0, LS_B, 0);
    issue(0, 13, 0, LS_BU, 0);
  endtask

  task automatic test_half;
    issue(1, 22, 32'h0000ABCD, LS_H, 0);
    checks++;
    if (lat !== 2 || log_addr[0] !== 20 || log_be[0] !== 4'b1100 || log_wd[0] !== 32'hABCD0000) begin
      errors++; $display("FAIL sh22 got lat=%0d addr=%h be=%b wd=%h want 2 14 1100 abcd0000", lat, log_addr[0], log_be[0], log_wd[0]);
    end
    issue(0, 22, 0, LS_H, 0);
    issue(0, 22, 0, LS_HU, 0);
  endtask

  task automatic test_split;
    issue(1, 6, 32'h11223344, LS_W, 0);
    checks++;
    if (lat !== 3 || nacc !== 2 || log_addr[0] !== 4 || log_be[0] !== 4'b1100 || log_wd[0] !== 32'h33440000) begin
      errors++; $display("FAIL sw6_acc1 got lat=%0d addr=%h be=%b wd=%h want 3 4 1100 33440000", lat, log_addr[0], log_be[0], log_wd[0]);
    end
    checks++;
    if (log_addr[1] !== 8 || log_be[1] !== 4'b0011 || log_wd[1] !== 32'h00001122 || log_we[1] !== 1) begin
      errors++; $display("FAIL sw6_acc2 got addr=%h be=%b wd=%h we=%b want 8 0011 00001122 1", log_addr[1], log_be[1], log_wd[1], log_we[1]);
    end
    issue(0, 6, 0, LS_W, 0);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lw6_lat got %0d want 3", lat); end
    issue(0, 15, 0, LS_HU, 0);
  endtask

  task automatic test_errors;
    logic [32:0] exp;
    issue(0, 32'h10, 0, 3'b011, 1);
    checks++;
    if (lat !== 1 || nacc !== 0 || mem_we !== 0) begin
      errors++; $display("FAIL bad_mode got lat=%0d nacc=%0d we=%b want 1 0 0", lat, nacc, mem_we);
    end
    issue(1, 0, 32'h12345678, 3'b111, 1);
    checks++;
    if (lat !== 1 || mem_words[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bad_store got lat=%0d word0=%h want 1 deadbeef", lat, mem_words[0]);
    end
    sb.push_back({1'b1, 32'h0});
    @(negedge clk);
    req_valid0 = 1; req_write = 0; req_addr = 6; req_mode = LS_W;
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 0;
    exp = sb.pop_front();
    checks++;
    if (resp_valid0 !== 1 || {resp_err0, resp_rdata0} !== exp || {mem_we0, mem_be0, mem_addr0, mem_wdata0} !== '0) begin
      errors++; $display("FAIL noalign_err got rv=%b err=%b data=%h be=%b want 1 1 0 0000", resp_valid0, resp_err0, resp_rdata0, mem_be0);
    end
    sb.push_back({1'b0, exp_load(0, LS_W)});
    @(negedge clk);
    req_valid0 = 1; req_addr = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 0;
    checks++;
    if (mem_be0 !== 4'b1111 || mem_addr0 !== 0 || mem_we0 !== 0) begin
      errors++; $display("FAIL noalign_lw_acc got be=%b addr=%h we=%b want 1111 0 0", mem_be0, mem_addr0, mem_we0);
    end
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if (resp_valid0 !== 1 || {resp_err0, resp_rdata0} !== exp) begin
      errors++; $display("FAIL noalign_lw got rv=%b err=%b data=%h want 1 %b %h", resp_valid0, resp_err0, resp_rdata0, exp[32], exp[31:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp;
    int pulses = 0;
    repeat (3) sb.push_back({1'b0, exp_load(0, LS_W)});
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 0; req_mode = LS_W;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); @(negedge clk);
      if (resp_valid) begin
        pulses++;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_extra got pulse %0d want 3 pulses", pulses); end
        else begin
          exp = sb.pop_front();
          if ({resp_err, resp_rdata} !== exp) begin
            errors++; $display("FAIL b2b_data got %b %h want %b %h", resp_err, resp_rdata, exp[32], exp[31:0]);
          end
        end
      end
    end
    req_valid = 0;
    checks++;
    if (pulses !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", pulses); end
    sb.delete();
  endtask

  task automatic test_reset_abort;
    int pulses = 0;
    issue(1, 4, 32'h55667788, LS_W, 0);
    issue(1, 8, 32'h99AABBCC, LS_W, 0);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 6; req_wdata = 32'h11223344; req_mode = LS_W;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    checks++;
    if (req_ready !== 1 || mem_we !== 0 || mem_be !== 0 || resp_valid !== 0) begin
      errors++; $display("FAIL abort_idle got ready=%b we=%b be=%b rv=%b want 1 0 0 0", req_ready, mem_we, mem_be, resp_valid);
    end
    repeat (3) begin @(negedge clk); pulses += resp_valid; end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_pulse got %0d want 0", pulses); end
    ref_mem[6] = 8'h44; ref_mem[7] = 8'h33;
    checks++;
    if (mem_words[1] !== 32'h33447788 || mem_words[2] !== 32'h99AABBCC) begin
      errors++; $display("FAIL abort_mem got w4=%h w8=%h want 33447788 99aabbcc", mem_words[1], mem_words[2]);
    end
    issue(0, 4, 0, LS_W, 0);
    issue(0, 8, 0, LS_W, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 0;
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_split;
    test_errors;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
